calc_engine: RTL and testbench

- Arithmetic core of the FPGA calculator, directly upstream of the 4-digit seven-segment display driver.
- Latches two unsigned operands and an opcode on a start pulse and computes the result.
  - Add and subtract finish in one cycle.
  - Multiply (shift-add) and divide (restoring) are iterative.
- Presents a held 13-bit unsigned result on Result, which connects straight to the display's 13-bit input, plus status flags.

---
 rtl/calc_engine.sv | 156 +++++++++++++++
 tb/tb_calc_engine.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/calc_engine.sv
// Calculator arithmetic core: add/sub in one cycle, shift-add multiply and restoring divide in OPW cycles.
// Optional build macro CALC_SAT_EN clamps out-of-range results instead of wrapping them.
module calc_engine #(
    parameter int OPW = 8,
    parameter int RW  = 13
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] A,
    input  logic [OPW-1:0] B,
    input  logic [1:0]     Op,
    input  logic           Start,
    output logic [RW-1:0]  Result,
    output logic           Busy,
    output logic           Done,
    output logic           Err
);

    localparam int FW = ((2 * OPW > RW) ? 2 * OPW : RW) + 1;
    localparam int CW = $clog2(OPW);
    localparam logic [FW-1:0] MAXV = FW'((1 << RW) - 1);
    localparam logic [CW-1:0] LAST = CW'(OPW - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [2:0]       state;
    logic [OPW-1:0]   a_r;
    logic [OPW-1:0]   b_r;
    logic [1:0]       op_r;
    logic [CW-1:0]    cnt;
    logic [2*OPW-1:0] prod;
    logic [2*OPW-1:0] mcand;
    logic [OPW-1:0]   rem;

    // Restoring-divide step: a_r shifts dividend bits out the top and quotient bits in the bottom.
    logic [OPW:0]   rem_next;
    logic           sub_ok;
    logic [OPW-1:0] rem_sub;

    assign rem_next = {rem, a_r[OPW-1]};
    assign sub_ok   = (rem_next >= {1'b0, b_r});
    assign rem_sub  = OPW'(rem_next - {1'b0, b_r});

    logic [FW-1:0] full;
    logic          neg;
    logic          dz;
    logic          ovf;
    logic [RW-1:0] res_c;
    logic          err_c;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        full = '0;
        neg  = 1'b0;
        dz   = 1'b0;
        case (op_r)
            OP_ADD: full = FW'(a_r) + FW'(b_r);
            OP_SUB: begin
                full = FW'(a_r) - FW'(b_r);
                neg  = (a_r < b_r);
            end
            OP_MUL: full = FW'(prod);
            OP_DIV: begin
                full = FW'(a_r);
                dz   = (b_r == '0);
            end
            default: full = '0;
        endcase
        ovf   = !neg && !dz && (full > MAXV);
        err_c = neg || dz || ovf;
`ifdef CALC_SAT_EN
        if (dz || neg)
            res_c = '0;
        else if (ovf)
            res_c = MAXV[RW-1:0];
        else
            res_c = full[RW-1:0];
`else
        res_c = dz ? '0 : full[RW-1:0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= OP_ADD;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            rem    <= '0;
            Result <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Err    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        a_r   <= A;
                        b_r   <= B;
                        op_r  <= Op;
                        cnt   <= '0;
                        prod  <= '0;
                        mcand <= {{OPW{1'b0}}, A};
                        rem   <= '0;
                        Busy  <= 1'b1;
                        if (Op == OP_MUL)
                            state <= S_MUL;
                        else if (Op == OP_DIV && B != '0)
                            state <= S_DIV;
                        else
                            state <= S_EXEC;
                    end
                end
                S_MUL: begin
                    if (b_r[0])
                        prod <= prod + mcand;
                    mcand <= mcand << 1;
                    b_r   <= b_r >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= S_FIN;
                end
                S_DIV: begin
                    rem   <= sub_ok ? rem_sub : rem_next[OPW-1:0];
                    a_r   <= {a_r[OPW-2:0], sub_ok};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= S_FIN;
                end
                S_EXEC, S_FIN: begin
                    Result <= res_c;
                    Err    <= err_c;
                    Done   <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_engine.sv
// Directed self-checking bench for calc_engine; expected values are hand-computed
// (define CALC_SAT_EN for both RTL and bench to check the clamping build).
module tb_calc_engine;

    logic        CLK;
    logic        RST;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [1:0]  Op;
    logic        Start;
    logic [12:0] Result;
    logic        Busy;
    logic        Done;
    logic        Err;

    int checks;
    int errors;
    int prev_res;

    calc_engine #(.OPW(8), .RW(13)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .A      (A),
        .B      (B),
        .Op     (Op),
        .Start  (Start),
        .Result (Result),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one operation, then check it completes exactly lat cycles after the Start edge.
    // With poke set, Start is toggled and operands scrambled while Busy to show they are ignored.
    task automatic run(input string tag, input int a, input int b, input int op, input int lat,
                       input int exp_res, input int exp_err, input bit poke);
        @(negedge CLK);
        A = 8'(a); B = 8'(b); Op = 2'(op); Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        check({tag, "_busy"}, 32'(Busy), 1);
        check({tag, "_nodone0"}, 32'(Done), 0);
        for (int i = 1; i < lat; i++) begin
            if (poke) begin
                Start = i[0];
                A = 8'(~a);
                B = 8'(a);
                Op = 2'(op + 1);
            end
            @(posedge CLK); #1;
            check({tag, "_early_done"}, 32'(Done), 0);
            check({tag, "_held"}, 32'(Result), 32'(prev_res));
        end
        if (poke) begin
            Start = 1'b1;
            A = 8'(a); B = 8'(b); Op = 2'(op);
        end
        @(posedge CLK); #1;
        Start = 1'b0;
        check({tag, "_done"}, 32'(Done), 1);
        check({tag, "_idle"}, 32'(Busy), 0);
        check({tag, "_result"}, 32'(Result), 32'(exp_res));
        check({tag, "_err"}, 32'(Err), 32'(exp_err));
        prev_res = exp_res;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev_res = 0;
        RST = 1'b1; A = '0; B = '0; Op = '0; Start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_result", 32'(Result), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_err", 32'(Err), 0);
        @(negedge CLK);
        RST = 1'b0;

        run("add", 200, 100, 0, 1, 300, 0, 1'b0);
        @(posedge CLK); #1;
        check("add_pulse_one", 32'(Done), 0);

`ifdef CALC_SAT_EN
        run("sub_neg", 5, 9, 1, 1, 0, 1, 1'b0);
`else
        run("sub_neg", 5, 9, 1, 1, 8188, 1, 1'b0);
`endif
        run("sub_pos", 9, 5, 1, 1, 4, 0, 1'b0);

        run("mul", 90, 91, 2, 9, 8190, 0, 1'b1);
        @(posedge CLK); #1;
        check("mul_no_extra_done", 32'(Done), 0);
        check("mul_no_restart", 32'(Busy), 0);

        // Back-to-back: the second Start is sampled at the edge right after Done.
        run("div", 250, 7, 3, 9, 35, 0, 1'b0);
        run("div0", 9, 0, 3, 1, 0, 1, 1'b0);

`ifdef CALC_SAT_EN
        run("mul_ovf", 255, 255, 2, 9, 8191, 1, 1'b0);
`else
        run("mul_ovf", 255, 255, 2, 9, 7681, 1, 1'b0);
`endif

        // Reset at edge k+4 of a multiply: abort with no Done, outputs cleared.
        @(negedge CLK);
        A = 8'd90; B = 8'd91; Op = 2'b10; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        check("rmul_busy", 32'(Busy), 1);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rmul_busy_clr", 32'(Busy), 0);
        check("rmul_result_clr", 32'(Result), 0);
        check("rmul_err_clr", 32'(Err), 0);
        check("rmul_done", 32'(Done), 0);
        @(negedge CLK);
        RST = 1'b0;
        prev_res = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            check("rmul_no_done", 32'(Done), 0);
        end

        run("add_after_rst", 1, 1, 0, 1, 2, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
